// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// Imported by dmem_arbiter and dmem_arb_rdtrack.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_MEM_LAT  = 1;
    localparam int DEF_LOCK_MAX = 8;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

    // The round-robin pointer always moves to the requester that just lost.
    function automatic owner_e other_owner(owner_e o);
        return (o == OWN_CPU) ? OWN_HOST : OWN_CPU;
    endfunction

endpackage

// File: rtl/dmem_arb_rdtrack.sv
// Read-return tracker: MEM_LAT-deep tag pipeline that follows each issued read
// and steers mem_rdata into the owning requester's rdata/rvalid registers.
module dmem_arb_rdtrack
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              issue_rd,
    input  logic              issue_host,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata
);

    tag_t tags [MEM_LAT];
    tag_t tag_out;
    logic ret_cpu;
    logic ret_host;

    assign tag_out  = tags[MEM_LAT-1];
    assign ret_cpu  = tag_out.valid && (tag_out.owner == OWN_CPU);
    assign ret_host = tag_out.valid && (tag_out.owner == OWN_HOST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the tag pipeline is reset, unlike a data array, because a
            // surviving valid bit would produce an rvalid for a discarded read.
            for (int i = 0; i < MEM_LAT; i++) begin
                tags[i] <= '0;
            end
            cpu_rvalid  <= 1'b0;
            host_rvalid <= 1'b0;
            cpu_rdata   <= '0;
            host_rdata  <= '0;
        end else begin
            tags[0] <= '{valid: issue_rd, owner: (issue_host ? OWN_HOST : OWN_CPU)};
            for (int i = 1; i < MEM_LAT; i++) begin
                tags[i] <= tags[i-1];
            end
            cpu_rvalid  <= ret_cpu;
            host_rvalid <= ret_host;
            if (ret_cpu) begin
                cpu_rdata <= mem_rdata;
            end
            if (ret_host) begin
                host_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between CPU MEM stage
// and host port. Define DMEM_ARB_LOCK_EN to enable the host exclusive lock.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MEM_LAT  = DEF_MEM_LAT,
    parameter int LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_lock,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e state;
    owner_e favour;
    logic   issue_host;
    logic   issue_rd;

`ifdef DMEM_ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    localparam int unused_lock_max = LOCK_MAX;
    logic unused_lock;
    assign unused_lock = host_lock;
`endif

    always_comb begin
        // NOTE: both grants get a default before any branch so no path through
        // this block leaves them unassigned and infers a latch.
        cpu_gnt  = 1'b0;
        host_gnt = 1'b0;
        if (resetn) begin
            if (state == LOCKED) begin
                host_gnt = host_req;
            end else if (cpu_req && host_req) begin
                cpu_gnt  = (favour == OWN_CPU);
                host_gnt = (favour == OWN_HOST);
            end else begin
                cpu_gnt  = cpu_req;
                host_gnt = host_req;
            end
        end
    end

    assign cpu_stall = resetn && cpu_req && !cpu_gnt;
    assign issue_rd  = mem_en && !mem_wr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ARB;
            favour     <= OWN_CPU;
            mem_en     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            issue_host <= 1'b0;
`ifdef DMEM_ARB_LOCK_EN
            wait_cnt   <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register here sampling
            // this cycle's values, independent of statement order.
            mem_en <= cpu_gnt || host_gnt;
            if (host_gnt) begin
                mem_wr     <= host_wr;
                mem_addr   <= host_addr;
                mem_wdata  <= host_wdata;
                issue_host <= 1'b1;
                favour     <= other_owner(OWN_HOST);
            end else if (cpu_gnt) begin
                mem_wr     <= cpu_wr;
                mem_addr   <= cpu_addr;
                mem_wdata  <= cpu_wdata;
                issue_host <= 1'b0;
                favour     <= other_owner(OWN_CPU);
            end else begin
                mem_wr <= 1'b0;
            end

`ifdef DMEM_ARB_LOCK_EN
            // On a counter exit the pointer already favours the CPU, since only
            // the host was granted while locked.
            case (state)
                ARB: begin
                    if (host_gnt && host_lock) begin
                        state    <= LOCKED;
                        wait_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (!host_lock) begin
                        state <= ARB;
                    end else if (cpu_req) begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == CNT_W'(LOCK_MAX - 1)) begin
                            state <= ARB;
                        end
                    end
                end
                default: state <= ARB;
            endcase
`else
            state <= ARB;
`endif
        end
    end

    dmem_arb_rdtrack #(
        .DATA_W (DATA_W),
        .MEM_LAT(MEM_LAT)
    ) u_rdtrack (
        .clk        (clk),
        .resetn     (resetn),
        .issue_rd   (issue_rd),
        .issue_host (issue_host),
        .mem_rdata  (mem_rdata),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata)
    );

endmodule
